// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package adder_pkg;

  localparam int WIDTH_DEF = 32'sd16;
  localparam int GROUP_DEF = 32'sd4;

  // Number of pipeline stages: one CLA slice per stage.
  function automatic int nstg(input int width, input int group);
    return width / group;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_group.sv
// Combinational GROUP-bit carry-lookahead slice. Every carry is the flat
// sum-of-products expansion of G/P terms, so there is no ripple inside the slice.
module cla_group
  import adder_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             acc;
  logic             prod;

  assign p = a ^ b;
  assign g = a & b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin.
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int m = j + 1; m <= i; m++) begin
          prod = prod & p[m];
        end
        acc = acc | prod;
      end
      prod = cin;
      for (int m = 0; m <= i; m++) begin
        prod = prod & p[m];
      end
      c[i+1] = acc | prod;
    end
  end

  assign s     = p ^ c[GROUP-1:0];
  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one GROUP-bit CLA slice per stage,
// carries passed between slices only through stage registers, valid/ready on
// both sides with a single global advance (the whole pipe holds on stall).
//
// Each stage register is one packed word: the sum slices already produced sit
// in the low bits, the operand pairs {b_j, a_j} still waiting for their slice
// sit above them, and the top bit is the signed-overflow flag of the newest
// slice. The last stage's word is therefore exactly {OVF, S}.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             OVF
);

  localparam int NSTG = nstg(WIDTH, GROUP);
  localparam int WW   = 2 * WIDTH;

  if ((WIDTH % GROUP) != 32'sd0) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end

  logic          adv;
  logic          c0;
  logic [WW-1:0] packed_in;

  // One shared advance: results move on unless a held result is blocked.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Operand prep: invert B and force carry-in for subtract, interleave slices.
  always_comb begin
    packed_in = '0;
    c0        = SUB ? 1'b1 : Cin;
    for (int j = 0; j < NSTG; j++) begin
      packed_in[2*GROUP*j +: GROUP]         = A[GROUP*j +: GROUP];
      packed_in[2*GROUP*j + GROUP +: GROUP] = SUB ? ~B[GROUP*j +: GROUP] : B[GROUP*j +: GROUP];
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int DONE = k * GROUP;
    localparam int WO   = WW - (k + 1) * GROUP;
    localparam logic [WW:0] ONE      = {{WW{1'b0}}, 1'b1};
    localparam logic [WW:0] LOW_MASK = (ONE << DONE) - ONE;

    logic [WW:0]      in_word;
    logic             c_in;
    logic             v_in;
    logic [GROUP-1:0] s_slice;
    logic             c_out;
    logic             c_msb;
    logic [WO-1:0]    next_word;
    logic [WO:0]      word_r;
    logic             c_r;
    logic             v_r;

    if (k == 0) begin : g_src
      assign in_word = {1'b0, packed_in};
      assign c_in    = c0;
      assign v_in    = in_valid;
    end else begin : g_src
      assign in_word = {{DONE{1'b0}}, g_stg[k-1].word_r};
      assign c_in    = g_stg[k-1].c_r;
      assign v_in    = g_stg[k-1].v_r;
    end

    cla_group #(.GROUP(GROUP)) u_cla (
      .a     (in_word[DONE +: GROUP]),
      .b     (in_word[DONE + GROUP +: GROUP]),
      .cin   (c_in),
      .s     (s_slice),
      .cout  (c_out),
      .c_msb (c_msb)
    );

    // Replace the consumed operand pair with its sum slice; keep the rest.
    assign next_word = WO'(((in_word >> (DONE + 2 * GROUP)) << (DONE + GROUP))
                         | ({{(WW + 1 - GROUP){1'b0}}, s_slice} << DONE)
                         | (in_word & LOW_MASK));

    // Stage register: valid follows the pipe, data only loads for real beats.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r    <= 1'b0;
        c_r    <= 1'b0;
        word_r <= '0;
      end else if (adv) begin
        v_r <= v_in;
        if (v_in) begin
          c_r    <= c_out;
          word_r <= {c_out ^ c_msb, next_word};
        end
      end
    end
  end

  assign out_valid = g_stg[NSTG-1].v_r;
  assign S         = g_stg[NSTG-1].word_r[WIDTH-1:0];
  assign OVF       = g_stg[NSTG-1].word_r[WIDTH];
  assign Cout      = g_stg[NSTG-1].c_r;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder at WIDTH=16, GROUP=4.
module tb_pipelined_cla_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         Cin = 1'b0;
  logic         SUB = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] S;
  logic         Cout;
  logic         OVF;

  int           n_tests = 0;
  int           n_fail = 0;
  int           n_pop = 0;
  logic [17:0]  exp_q[$];
  logic [W-1:0] last_s = '0;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .OVF(OVF)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {OVF, Cout, S}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [16:0] sum;
    logic [15:0] bb;
    logic        ovf;
    bb  = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
    ovf = (a[15] == bb[15]) && (sum[15] != a[15]);
    return {ovf, sum[16], sum[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: check every meaningful output cycle against the model queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (~out_valid | out_ready)});
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", 32'd1, 32'd0);
        end else begin
          check("result", {14'd0, OVF, Cout, S}, {14'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end else begin
        check("s_quiet_when_idle", {16'd0, S}, {16'd0, last_s});
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cin, SUB));
    end
    last_s = S;
  end

  // One beat through an idle pipe, checking latency and hand-computed result.
  task automatic run_one(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic eo);
    int cyc;
    A = a; B = b; Cin = cin; SUB = sub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, 32'd4);
    check({nm, "_S"}, {16'd0, S}, {16'd0, es});
    check({nm, "_Cout"}, {31'd0, Cout}, {31'd0, ec});
    check({nm, "_OVF"}, {31'd0, OVF}, {31'd0, eo});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   sent;
    int   cyc;
    int   pop0;
    int   bound;
    logic accepted;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_S", {16'd0, S}, 32'd0);
    check("rst_Cout", {31'd0, Cout}, 32'd0);
    check("rst_OVF", {31'd0, OVF}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_one("add_small",   16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
    run_one("wrap_b1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("wrap_cin",    16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("sub_borrow",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_one("carry_chain", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Streaming: 8 back-to-back beats, downstream stalls for cycles 4..6.
    pop0 = n_pop;
    sent = 0;
    cyc = 0;
    accepted = 1'b1;
    while (sent < 8 && cyc < 100) begin
      if (accepted) begin
        A = 16'($urandom); B = 16'($urandom);
        Cin = 1'($urandom_range(0, 1)); SUB = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b1;
      out_ready = !(cyc >= 4 && cyc < 7);
      if (cyc == 5) check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (accepted) sent++;
    end
    check("stream_sent", sent, 32'd8);
    in_valid = 1'b0;
    out_ready = 1'b1;
    bound = 0;
    while (exp_q.size() > 0 && bound < 50) begin
      @(posedge clk); #1;
      bound++;
    end
    check("stream_drained", exp_q.size(), 32'd0);
    check("stream_count", n_pop - pop0, 32'd8);

    // Leave a nonzero result on S, then reset with three beats in flight.
    run_one("pre_reset", 16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      A = 16'h1111 * 16'(i + 1); B = 16'h0101; Cin = 1'b0; SUB = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_S", {16'd0, S}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_one("post_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    check("post_reset_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
